iob_reset_sequencer: RTL and testbench
======================================

// Module: iob_reset_sequencer
// PURPOSE
//  Consumes the free-running clock from the clock generator and produces ordered
//  reset releases for N_RST downstream domains (e.g. core, peripherals, ethernet).
//  Asynchronous assertion, synchronous staged de-assertion, a minimum hold time,
//  and a soft-reset request/acknowledge handshake for re-sequencing at run time.
// PARAMETERS
//  N_RST        3   number of sequenced reset outputs (>=1)
//  SYNC_STAGES  2   flops in arst_i de-assertion synchronizer (>=2)
//  HOLD_CYCLES  16  cycles all outputs stay asserted after sync release (>=1)
//  STEP_CYCLES  4   cycles between consecutive output releases (>=1)
//  CNT_W        localparam = $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1)
// PORTS
//  clk_i            in   1      clock, from the clock generator
//  arst_i           in   1      asynchronous reset, active high
//  soft_rst_req_i   in   1      soft reset request, level, held until ack
//  soft_rst_ack_o   out  1      one-cycle acknowledge of soft request
//  rst_o            out  N_RST  per-domain reset, active high; bit 0 released first
//  done_o           out  1      all domains released, sequence complete
// BEHAVIOUR
//  Reset: all clocked, asynchronous active-high reset on arst_i.
//  - arst_i=1: immediately rst_o='1, done_o=0, soft_rst_ack_o=0, state=SYNC, counter=0.
//  Edge numbering: edge 1 = first rising clk_i edge with arst_i=0.
//  - SYNC: shift chain loaded with 1s, shifts in 0; sync output falls at edge
//    SYNC_STAGES -> state HOLD, counter cleared.
//  - HOLD: counter increments; at HOLD_CYCLES-th edge in HOLD rst_o[0] <= 0,
//    index <= 1, state RELEASE (or DONE-pending if N_RST==1).
//  - RELEASE: every STEP_CYCLES edges rst_o[index] <= 0, index++; after bit N_RST-1
//    released, state DONE on that edge.
//  - DONE: done_o <= 1 one edge after rst_o[N_RST-1] falls.
//  Timing: rst_o[k] falls at edge SYNC_STAGES+HOLD_CYCLES+k*STEP_CYCLES;
//    done_o rises at edge SYNC_STAGES+HOLD_CYCLES+(N_RST-1)*STEP_CYCLES+1.
//  - rst_o bits released strictly in index order; a released bit never re-asserts
//    except via arst_i or an accepted soft request.
//  Soft reset handshake:
//  - soft_rst_req_i sampled only in DONE. Sampled 1 at edge E: soft_rst_ack_o=1 for
//    exactly the cycle after E, rst_o='1, done_o=0, state HOLD, counter=0
//    (synchronizer skipped). rst_o[0] then falls at E+HOLD_CYCLES.
//  - Request while not DONE: ignored, no ack; acted on once DONE is reached.
//  - Request still high after ack: new request only if it is low for >=1 cycle
//    first (edge-armed); a held level never causes back-to-back sequences.
//  Boundary cases:
//  - arst_i asserted mid-sequence or mid-handshake: full restart from SYNC, pending
//    ack dropped, arm flag cleared.
//  - arst_i pulse shorter than a clock period: still asserts all outputs, full sequence.
//  - Counter never wraps: it is cleared on every state/index transition.
//  - rst_o and done_o are flop outputs (glitch-free); no combinational paths in->out.
// STRUCTURE
//  - iob_reset_sequencer_conf.vh: parameter defaults, state encodings
//    (SYNC=0, HOLD=1, RELEASE=2, DONE=3), CNT_W helper macro.
//  - Sub-module iob_reset_sync: SYNC_STAGES-deep async-assert/sync-deassert chain
//    (clk_i, arst_i -> rst_sync_o); remainder (FSM, counter, index, handshake) inline.
// TESTING  (defaults unless stated; clock from iob_clock, CLK_PERIOD 10)
//  1 arst_i 1->0 -> rst_o[0] falls edge 18, rst_o[1] edge 22, rst_o[2] edge 26,
//    done_o=1 at edge 27; order and exact edges checked.
//  2 arst_i pulsed at edge 20 (mid-RELEASE) -> rst_o=3'b111 and done_o=0 within the
//    same time step; sequence restarts, rst_o[0] falls 18 edges after release.
//  3 DONE, soft_rst_req_i=1 at edge E -> ack high one cycle, rst_o=3'b111,
//    rst_o[0] falls E+16, rst_o[2] falls E+24, done_o at E+25.
//  4 soft_rst_req_i held high 100 cycles -> exactly one ack and one sequence.
//  5 soft_rst_req_i raised during HOLD -> no ack until done_o=1, then ack next cycle.
//  6 N_RST=1, HOLD_CYCLES=1, SYNC_STAGES=2 -> rst_o falls edge 3, done_o edge 4.

Source files
------------

// File: rtl/iob_reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: default parameters, FSM states
// and the counter-width helper.
package iob_reset_sequencer_pkg;

  localparam int DEF_N_RST       = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STEP_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // Wide enough to hold the larger of the hold and step cycle counts.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int max_v;
    max_v = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/iob_reset_sequencer_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer chain.
// The output rises immediately with arst_i and falls SYNC_STAGES edges after release.
module iob_reset_sequencer_sync
  import iob_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic arst_i,
  output logic rst_sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_reset_sequencer.sv
// Ordered reset release for N_RST domains with hold time, fixed release spacing
// and an edge-armed soft-reset request/acknowledge handshake.
module iob_reset_sequencer
  import iob_reset_sequencer_pkg::*;
#(
  parameter int N_RST       = DEF_N_RST,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             soft_rst_req_i,
  output logic             soft_rst_ack_o,
  output logic [N_RST-1:0] rst_o,
  output logic             done_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_RST - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_RST-1:0] rst_q, rst_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             arm_q, arm_d;
  logic             rst_sync;
  logic             release_first;
  logic             accept;

  iob_reset_sequencer_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .rst_sync_o(rst_sync)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      arm_q   <= arm_d;
    end
  end

  // The edge on which SYNC first sees the synchronizer low already counts as
  // the first hold cycle, so the hold window ends SYNC_STAGES+HOLD_CYCLES edges in.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    rst_d         = rst_q;
    done_d        = done_q;
    ack_d         = 1'b0;
    release_first = 1'b0;
    accept        = (state_q == ST_DONE) && done_q && soft_rst_req_i && arm_q;
    arm_d         = accept ? 1'b0 : (arm_q | ~soft_rst_req_i);

    case (state_q)
      ST_SYNC: begin
        if (!rst_sync) begin
          if (HOLD_CYCLES == 1) begin
            release_first = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          release_first = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          for (int k = 0; k < N_RST; k++) begin
            if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (accept) begin
          ack_d   = 1'b1;
          rst_d   = '1;
          done_d  = 1'b0;
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (release_first) begin
      rst_d[0] = 1'b0;
      idx_d    = IDX_W'(1);
      cnt_d    = '0;
      state_d  = (N_RST == 1) ? ST_DONE : ST_RELEASE;
    end
  end

  assign rst_o          = rst_q;
  assign done_o         = done_q;
  assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Self-checking bench for iob_reset_sequencer: timing tables, handshake corner
// cases, an N_RST=1 instance, and random stimulus against a timing-formula model.
module tb_iob_reset_sequencer;

  localparam int N     = 3;
  localparam int SYNC  = 2;
  localparam int HOLD  = 16;
  localparam int STEP  = 4;

  logic       clk_i = 1'b0;
  logic       arst_i = 1'b1;
  logic       req_i = 1'b0;
  logic       ack_o;
  logic [2:0] rst_o;
  logic       done_o;

  logic       arst1_i = 1'b1;
  logic       ack1_o;
  logic [0:0] rst1_o;
  logic       done1_o;

  int checks = 0;
  int errors = 0;

  iob_reset_sequencer dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .soft_rst_req_i(req_i),
    .soft_rst_ack_o(ack_o),
    .rst_o         (rst_o),
    .done_o        (done_o)
  );

  iob_reset_sequencer #(
    .N_RST      (1),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(1),
    .STEP_CYCLES(4)
  ) dut1 (
    .clk_i         (clk_i),
    .arst_i        (arst1_i),
    .soft_rst_req_i(1'b0),
    .soft_rst_ack_o(ack1_o),
    .rst_o         (rst1_o),
    .done_o        (done1_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: tracks the edge at which rst_o[0] must fall and derives
  // every other output from the release-time formulas.
  int edge_n = 0;
  int fall0 = SYNC + HOLD;
  int pulse_cnt = 0;
  int pulse_handled = 0;
  bit armed = 1'b0;
  bit ack_exp = 1'b0;

  always @(posedge arst_i) pulse_cnt++;

  function automatic bit in_reset();
    return arst_i || (pulse_cnt != pulse_handled);
  endfunction

  function automatic int done_edge();
    return fall0 + (N - 1) * STEP + 1;
  endfunction

  function automatic logic [2:0] exp_rst();
    logic [2:0] r;
    r = '1;
    if (!in_reset()) begin
      for (int k = 0; k < N; k++) r[k] = (edge_n < fall0 + k * STEP);
    end
    return r;
  endfunction

  function automatic logic exp_done();
    return !in_reset() && (edge_n >= done_edge());
  endfunction

  function automatic logic exp_ack();
    return !in_reset() && ack_exp;
  endfunction

  always @(posedge clk_i) begin
    bit done_before;
    bit accept;
    done_before = exp_done();
    edge_n++;
    if (arst_i) begin
      pulse_handled = pulse_cnt;
      fall0   = edge_n + SYNC + HOLD;
      armed   = 1'b0;
      ack_exp = 1'b0;
    end else begin
      if (pulse_cnt != pulse_handled) begin
        pulse_handled = pulse_cnt;
        fall0       = edge_n - 1 + SYNC + HOLD;
        armed       = 1'b0;
        done_before = 1'b0;
      end
      accept  = done_before && req_i && armed;
      ack_exp = accept;
      if (!req_i) armed = 1'b1;
      if (accept) begin
        armed = 1'b0;
        fall0 = edge_n + HOLD;
      end
    end
  end

  task automatic applyStimulus(input logic arst_v, input logic req_v);
    arst_i = arst_v;
    req_i  = req_v;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  typedef struct {
    int         edge_no;
    logic [2:0] rst;
    logic       done;
    logic       ack;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cur;
    int ack_count;
    int premature;
    bit seen_done;
    int hold_left;

    vecs[0] = '{1,  3'b111, 1'b0, 1'b0};
    vecs[1] = '{2,  3'b111, 1'b0, 1'b0};
    vecs[2] = '{17, 3'b111, 1'b0, 1'b0};
    vecs[3] = '{18, 3'b110, 1'b0, 1'b0};
    vecs[4] = '{21, 3'b110, 1'b0, 1'b0};
    vecs[5] = '{22, 3'b100, 1'b0, 1'b0};
    vecs[6] = '{25, 3'b100, 1'b0, 1'b0};
    vecs[7] = '{26, 3'b000, 1'b0, 1'b0};
    vecs[8] = '{27, 3'b000, 1'b1, 1'b0};

    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("reset_rst", rst_o, 3'b111);
    checkOutput("reset_done", 3'(done_o), 3'b000);
    checkOutput("reset_ack", 3'(ack_o), 3'b000);
    checkOutput("reset1_rst", 3'(rst1_o), 3'b001);

    // Power-on release timing
    applyStimulus(1'b0, 1'b0);
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].edge_no - cur);
      cur = vecs[i].edge_no;
      checkOutput($sformatf("seq_rst_e%0d", cur), rst_o, vecs[i].rst);
      checkOutput($sformatf("seq_done_e%0d", cur), 3'(done_o), 3'(vecs[i].done));
      checkOutput($sformatf("seq_ack_e%0d", cur), 3'(ack_o), 3'(vecs[i].ack));
    end

    // Soft request accepted at edge E
    applyStimulus(1'b0, 1'b1);
    tick(1);
    checkOutput("soft_ack", 3'(ack_o), 3'b001);
    checkOutput("soft_rst", rst_o, 3'b111);
    checkOutput("soft_done", 3'(done_o), 3'b000);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    checkOutput("soft_ack_one_cycle", 3'(ack_o), 3'b000);
    tick(14);
    checkOutput("soft_rst_e15", rst_o, 3'b111);
    tick(1);
    checkOutput("soft_rst_e16", rst_o, 3'b110);
    tick(7);
    checkOutput("soft_rst_e23", rst_o, 3'b100);
    tick(1);
    checkOutput("soft_rst_e24", rst_o, 3'b000);
    checkOutput("soft_done_e24", 3'(done_o), 3'b000);
    tick(1);
    checkOutput("soft_done_e25", 3'(done_o), 3'b001);

    // Request held high for 100 cycles
    ack_count = 0;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ack_o === 1'b1) ack_count++;
    end
    checkCount("held_req_acks", ack_count, 1);
    checkOutput("held_req_done", 3'(done_o), 3'b001);
    applyStimulus(1'b0, 1'b0);
    tick(1);

    // Short arst pulse mid-RELEASE
    applyStimulus(1'b1, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(19);
    @(posedge clk_i);
    #1 arst_i = 1'b1;
    #1;
    checkOutput("pulse_rst", rst_o, 3'b111);
    checkOutput("pulse_done", 3'(done_o), 3'b000);
    #1 arst_i = 1'b0;
    tick(18);
    checkOutput("pulse_restart_e17", rst_o, 3'b111);
    tick(1);
    checkOutput("pulse_restart_e18", rst_o, 3'b110);

    // Request raised during HOLD waits for done
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    tick(5);
    applyStimulus(1'b0, 1'b1);
    premature = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      tick(1);
      if (done_o === 1'b1) seen_done = 1'b1;
      else if (ack_o === 1'b1) premature++;
    end
    checkCount("early_req_no_ack", premature, 0);
    checkCount("early_req_done_seen", int'(seen_done), 1);
    checkOutput("early_req_ack_at_done", 3'(ack_o), 3'b000);
    tick(1);
    checkOutput("early_req_ack_next", 3'(ack_o), 3'b001);
    applyStimulus(1'b0, 1'b0);

    // Single-domain instance, HOLD_CYCLES=1
    arst1_i = 1'b0;
    tick(2);
    checkOutput("n1_rst_e2", 3'(rst1_o), 3'b001);
    tick(1);
    checkOutput("n1_rst_e3", 3'(rst1_o), 3'b000);
    checkOutput("n1_done_e3", 3'(done1_o), 3'b000);
    tick(1);
    checkOutput("n1_done_e4", 3'(done1_o), 3'b001);
    checkOutput("n1_ack", 3'(ack1_o), 3'b000);

    // Random stimulus against the reference model
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      checkOutput("rnd_rst", rst_o, exp_rst());
      checkOutput("rnd_done", 3'(done_o), 3'(exp_done()));
      checkOutput("rnd_ack", 3'(ack_o), 3'(exp_ack()));
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) arst_i = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        if ($urandom_range(1) == 1) begin
          #1 arst_i = 1'b1;
          #1 checkOutput("rnd_pulse_rst", rst_o, 3'b111);
          #1 arst_i = 1'b0;
        end else begin
          arst_i = 1'b1;
          hold_left = int'($urandom_range(3, 1));
        end
      end
      if ($urandom_range(7) == 0) req_i = ~req_i;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
